fifo_wrarb: RTL

// - Round-robin write-port arbiter sharing one fifocvrt write side among NREQ requesters.
// - Grants are burst-atomic: the owner keeps the port until its last beat or MAXB beats.
// - Lives entirely in the FIFO write clock domain, with no CDC inside.
// - Drives wren/wdata of fifocvrt combinationally and honours wfull per beat.

---
 rtl/fifo_wrarb_pkg.sv | 17 +
 rtl/fifo_wrarb_if.sv | 29 ++
 rtl/fifo_wrarb_rr_pick.sv | 40 ++++
 rtl/fifo_wrarb.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fifo_wrarb_pkg.sv
// Shared types and helpers for the fifo_wrarb write-port arbiter.
package fifo_wrarb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // Ceiling log2 for elaboration-time width checks; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned x = 1; x < v; x = x << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wrarb_if.sv
// Requester/FIFO-side bundle of the write-port arbiter.
interface fifo_wrarb_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DATW = 8
);

  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      rlast;
  logic [NREQ*DATW-1:0] rdat;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic                 wfull;
  logic                 wren;
  logic [DATW-1:0]      wdata;
  logic                 busy;

  // Environment side: requesters plus the FIFO full flag.
  modport master (
    output req, rlast, rdat, wfull,
    input  gnt, ack, wren, wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  req, rlast, rdat, wfull,
    output gnt, ack, wren, wdata, busy
  );

endinterface

// File: rtl/fifo_wrarb_rr_pick.sv
// Round-robin pick: first set request searching upward from i_ptr+1, wrapping.
module fifo_wrarb_rr_pick
  import fifo_wrarb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned PW   = clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_onehot,
  output logic [PW-1:0]   o_idx,
  output logic            o_valid
);

  logic [NREQ-1:0] w_rot;
  logic [PW-1:0]   w_sel;

  function automatic logic [PW-1:0] wrap_idx(input int unsigned a);
    return PW'(a % NREQ);
  endfunction

  // Rotate so ptr+1 lands at bit 0, priority-encode, then un-rotate.
  always_comb begin
    w_rot    = '0;
    w_sel    = '0;
    o_valid  = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_rot[k] = i_req[wrap_idx(32'(i_ptr) + 32'd1 + k)];
    end
    for (int unsigned k = NREQ; k > 0; k--) begin
      if (w_rot[k-1]) begin
        o_valid = 1'b1;
        w_sel   = PW'(k - 1);
      end
    end
    o_idx    = wrap_idx(32'(i_ptr) + 32'd1 + 32'(w_sel));
    o_onehot = o_valid ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/fifo_wrarb.sv
// Burst-atomic round-robin arbiter sharing one FIFO write port among NREQ requesters.
module fifo_wrarb
  import fifo_wrarb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DATW = 8,
  parameter int unsigned MAXB = 16,
  parameter int unsigned CNTW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  fifo_wrarb_if.slave   bus
);

  localparam int unsigned PW = clog2(NREQ);

  if (NREQ < 2) begin : g_bad_nreq
    $error("fifo_wrarb: NREQ must be at least 2");
  end
  if (clog2(MAXB + 1) > CNTW) begin : g_bad_cntw
    $error("fifo_wrarb: CNTW too narrow to count MAXB beats");
  end

  state_e          r_state, w_state;
  logic [NREQ-1:0] r_gnt,   w_gnt;
  logic [PW-1:0]   r_own,   w_own;
  logic [PW-1:0]   r_ptr,   w_ptr;
  logic [CNTW-1:0] r_bcnt,  w_bcnt;

  logic [NREQ-1:0] w_ack;
  logic            w_acc;
  logic            w_last;
  logic            w_cap;
  logic            w_rel;
  logic [CNTW-1:0] w_bcnt_inc;
  logic [NREQ-1:0] w_pick_req;
  logic [PW-1:0]   w_pick_ptr;
  logic [NREQ-1:0] w_onehot;
  logic [PW-1:0]   w_idx;
  logic            w_valid;
  logic [DATW-1:0] w_wdata;

  // Beat acceptance, release detection and arbitration inputs.
  always_comb begin
    w_ack      = r_gnt & bus.req & {NREQ{~bus.wfull}};
    w_acc      = |w_ack;
    w_last     = bus.rlast[r_own];
    w_cap      = (MAXB != 0) && ((32'(r_bcnt) + 32'd1) == MAXB);
    w_rel      = w_acc && (w_last || w_cap);
    w_bcnt_inc = (&r_bcnt) ? r_bcnt : r_bcnt + CNTW'(1);
    w_pick_ptr = (r_state == BUSY) ? r_own : r_ptr;
    w_pick_req = bus.req;
    // A req carrying rlast is the beat just consumed, not a fresh request.
    if (w_rel && w_last) w_pick_req[r_own] = 1'b0;
  end

  fifo_wrarb_rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .i_req    (w_pick_req),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_onehot),
    .o_idx    (w_idx),
    .o_valid  (w_valid)
  );

  // Next-state logic.
  always_comb begin
    w_state = r_state;
    w_gnt   = r_gnt;
    w_own   = r_own;
    w_ptr   = r_ptr;
    w_bcnt  = r_bcnt;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state = BUSY;
          w_gnt   = w_onehot;
          w_own   = w_idx;
          w_bcnt  = '0;
        end
      end
      BUSY: begin
        if (w_rel) begin
          w_ptr  = r_own;
          w_bcnt = '0;
          if (w_valid) begin
            w_gnt = w_onehot;
            w_own = w_idx;
          end else begin
            w_state = IDLE;
            w_gnt   = '0;
          end
        end else if (w_acc) begin
          w_bcnt = w_bcnt_inc;
        end
      end
      default: begin
        w_state = IDLE;
        w_gnt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_own   <= '0;
      r_ptr   <= PW'(NREQ - 1);
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state;
      r_gnt   <= w_gnt;
      r_own   <= w_own;
      r_ptr   <= w_ptr;
      r_bcnt  <= w_bcnt;
    end
  end

  // AND-OR data mux; all-zero when nobody holds the grant.
  always_comb begin
    w_wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      w_wdata = w_wdata | (bus.rdat[i*DATW +: DATW] & {DATW{r_gnt[i]}});
    end
  end

  assign bus.gnt   = r_gnt;
  assign bus.ack   = w_ack;
  assign bus.wren  = w_acc;
  assign bus.wdata = w_wdata;
  assign bus.busy  = (r_state == BUSY);

endmodule
